// File: rtl/bsf_pkg.sv
// Shared types and the band-select rule for the banded scale FIFO.
// The BSF_ROUND_EN build option lives in bsf_xform; nothing here depends on it.
package bsf_pkg;

    localparam int unsigned BAND_W  = 2;
    localparam int unsigned PHASE_W = 32;

    typedef enum logic [BAND_W-1:0] {
        BAND_PASS  = 2'd0,
        BAND_HALF  = 2'd1,
        BAND_SHIFT = 2'd2,
        BAND_ZERO  = 2'd3
    } band_e;

    // Phase zero always passes through; otherwise the thresholds pick the band.
    function automatic band_e band_sel(input logic [PHASE_W-1:0] phase,
                                       input logic [PHASE_W-1:0] t_half,
                                       input logic [PHASE_W-1:0] t_shift);
        band_e band;
        if (phase == '0)
            band = BAND_PASS;
        else if (phase < t_half)
            band = BAND_HALF;
        else if (phase < t_shift)
            band = BAND_SHIFT;
        else
            band = BAND_ZERO;
        return band;
    endfunction

endpackage

// File: rtl/bsf_xform.sv
// Combinational band select and scale of one sample.
// Build option BSF_ROUND_EN: HALF/SHIFT bands round half-up instead of truncating.
module bsf_xform
    import bsf_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned T_HALF  = 'h80,
    parameter int unsigned T_SHIFT = 'hC0,
    parameter int unsigned SHIFT   = 2
) (
    input  logic [CNT_W-1:0] phase,
    input  logic [WIDTH-1:0] din,
    output band_e            band_c,
    output logic [WIDTH-1:0] dout_c
);

    logic [WIDTH-1:0] half_c;
    logic [WIDTH-1:0] shift_c;

`ifdef BSF_ROUND_EN
    localparam logic [WIDTH:0] HALF_RND  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] SHIFT_RND = (WIDTH+1)'(1) << (SHIFT - 1);

    // One extra bit holds the carry of the rounding add; the shifted result always fits WIDTH.
    logic [WIDTH:0] half_sum_c;
    logic [WIDTH:0] shift_sum_c;

    always_comb begin
        half_sum_c  = {1'b0, din} + HALF_RND;
        shift_sum_c = {1'b0, din} + SHIFT_RND;
        half_c      = WIDTH'(half_sum_c >> 1);
        shift_c     = WIDTH'(shift_sum_c >> SHIFT);
    end
`else
    always_comb begin
        half_c  = din >> 1;
        shift_c = din >> SHIFT;
    end
`endif

    always_comb begin
        band_c = band_sel(32'(phase), 32'(T_HALF), 32'(T_SHIFT));
        dout_c = '0;
        unique case (band_c)
            BAND_PASS:  dout_c = din;
            BAND_HALF:  dout_c = half_c;
            BAND_SHIFT: dout_c = shift_c;
            BAND_ZERO:  dout_c = '0;
            default:    dout_c = '0;
        endcase
    end

endmodule

// File: rtl/banded_scale_fifo.sv
// Transform-on-write FIFO: samples are scaled by a phase-selected band and drained in order.
// Rounding behaviour of the scale is selected by BSF_ROUND_EN inside bsf_xform.
module banded_scale_fifo
    import bsf_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned T_HALF  = 'h80,
    parameter int unsigned T_SHIFT = 'hC0,
    parameter int unsigned SHIFT   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_band,
    output logic [CNT_W-1:0]         phase,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned ENT_W = WIDTH + BAND_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count_nxt;
    logic             push;
    logic             pop;
    band_e            band_c;
    logic [WIDTH-1:0] xform_c;

    bsf_xform #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .T_HALF  (T_HALF),
        .T_SHIFT (T_SHIFT),
        .SHIFT   (SHIFT)
    ) u_xform (
        .phase  (phase),
        .din    (in_data),
        .band_c (band_c),
        .dout_c (xform_c)
    );

    // A full FIFO refuses input even if the head is popped in the same cycle.
    assign in_ready = (count != OCC_W'(DEPTH)) && !clr;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Show-ahead head of the ring.
    assign out_data = mem[rd_ptr][WIDTH-1:0];
    assign out_band = mem[rd_ptr][ENT_W-1 -: BAND_W];

    always_comb begin
        count_nxt = count;
        if (clr)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + OCC_W'(1);
        else if (pop && !push)
            count_nxt = count - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
        end else begin
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                phase  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= {band_c, xform_c};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                    phase       <= phase + CNT_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule
